// File: rtl/xsw_pkg.sv
// Shared types and helpers for the XSwNM destination-LUT configuration controller.
package xsw_pkg;

  localparam int unsigned MAX_M     = 16;
  localparam int unsigned LUT_MAX_W = MAX_M * MAX_M;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    UPDATE = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Identity routing table: entry d selects output d; result is LSB-aligned in an M*M field.
  function automatic logic [LUT_MAX_W-1:0] lut_identity(input int unsigned m);
    logic [LUT_MAX_W-1:0] lut;
    lut = '0;
    for (int unsigned d = 0; d < MAX_M; d++) begin
      if (d < m) lut = lut | (LUT_MAX_W'(1) << (d * m + d));
    end
    return lut;
  endfunction

  function automatic logic is_onehot(input logic [MAX_M-1:0] v);
    return (v != '0) && ((v & (v - MAX_M'(1))) == '0);
  endfunction

endpackage

// File: rtl/xsw_lock_tracker.sv
// Per-input occupancy lock: set by an accepted occupy beat, cleared by an accepted release beat.
module xsw_lock_tracker #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] fire,
  input  logic [N-1:0] ocy,
  input  logic [N-1:0] rel,
  output logic [N-1:0] lock,
  output logic         all_unlocked
);

  logic [N-1:0] lock_d;

  // An unlocked input only looks at ocy, so ocy+rel on the opening beat leaves it locked.
  always_comb begin
    lock_d = (lock & ~(fire & rel)) | (~lock & fire & ocy);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock <= '0;
    end else begin
      lock <= lock_d;
    end
  end

  assign all_unlocked = ~|lock;

endmodule

// File: rtl/xsw_lut_cfg_ctrl.sv
// Run-time writer for the switch destination LUT; quiesces inputs and drains open
// occupancy bursts before each single-entry update.
module xsw_lut_cfg_ctrl
  import xsw_pkg::*;
#(
  parameter int unsigned N        = 2,
  parameter int unsigned M        = 3,
  parameter int unsigned DRAIN_TO = 255,
  localparam int unsigned LU_N    = (M > 1) ? $clog2(M) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_req,
  input  logic [LU_N-1:0] cfg_dst,
  input  logic [M-1:0]    cfg_tgt,
  output logic            cfg_ack,
  output logic            cfg_err,
  output logic            busy,
  input  logic [N-1:0]    vld_us,
  output logic [N-1:0]    gnt_us,
  input  logic [N-1:0]    ocy_s,
  input  logic [N-1:0]    rel_s,
  output logic [N-1:0]    vld_sw,
  input  logic [N-1:0]    gnt_sw,
  output logic [M*M-1:0]  cfg_lut
);

  localparam int unsigned            CNT_W   = (DRAIN_TO > 1) ? $clog2(DRAIN_TO + 1) : 1;
  localparam logic [LUT_MAX_W-1:0]   ID_FULL = lut_identity(M);
  localparam logic [M*M-1:0]         ID_LUT  = ID_FULL[M*M-1:0];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic [LU_N-1:0]  dst_q, dst_d;
  logic [M-1:0]     tgt_q, tgt_d;
  logic [M*M-1:0]   lut_q, lut_d;
  logic             ack_d, err_d, busy_d;
  logic             req_ok, timeout;
  logic [N-1:0]     lock, gate, fire;
  logic             all_unlocked;

  // Input gating: unlocked inputs are held off while draining, everything during the write.
  always_comb begin
    gate = '0;
    if (state_q == DRAIN) begin
      gate = ~lock;
    end else if (state_q == UPDATE) begin
      gate = '1;
    end
  end

  assign vld_sw  = vld_us & ~gate;
  assign gnt_us  = gnt_sw & ~gate;
  assign fire    = vld_sw & gnt_sw;
  assign cfg_lut = lut_q;

  xsw_lock_tracker #(
    .N(N)
  ) u_lock (
    .clk          (clk),
    .rst          (rst),
    .fire         (fire),
    .ocy          (ocy_s),
    .rel          (rel_s),
    .lock         (lock),
    .all_unlocked (all_unlocked)
  );

  assign req_ok  = (32'(cfg_dst) < M) && is_onehot(MAX_M'(cfg_tgt));
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
  assign timeout = (DRAIN_TO != 0) && (32'(cnt_inc) == DRAIN_TO);

  // Next-state, datapath and response decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dst_d   = dst_q;
    tgt_d   = tgt_q;
    lut_d   = lut_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    busy_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_req) begin
          dst_d = cfg_dst;
          tgt_d = cfg_tgt;
          if (req_ok) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (all_unlocked) begin
          state_d = UPDATE;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
          if (timeout) begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      UPDATE: begin
        for (int unsigned d = 0; d < M; d++) begin
          if (dst_q == LU_N'(d)) lut_d[d*M +: M] = tgt_q;
        end
        state_d = RESP;
        ack_d   = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dst_q   <= '0;
      tgt_q   <= '0;
      lut_q   <= ID_LUT;
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
      tgt_q   <= tgt_d;
      lut_q   <= lut_d;
      cfg_ack <= ack_d;
      cfg_err <= err_d;
      busy    <= busy_d;
    end
  end

endmodule
